// File: rtl/tm1637_pkg.sv
// Shared constants and the FSM state type for the TM1637 refresh scheduler.
// Command bytes follow the TM1637 datasheet: data command, address command, display control.
package tm1637_pkg;

  localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0     = 8'hC0;
  localparam logic [7:0] CMD_CTRL_BASE = 8'h80;
  localparam int         CTRL_ON_BIT   = 3;
  localparam int         COLON_BIT     = 7;
  localparam int         COLON_DIGIT   = 1;

  typedef enum logic [2:0] {
    IDLE,
    DCMD,
    ADDR,
    DIG0,
    DIG1,
    DIG2,
    DIG3,
    CTRL
  } sched_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-HALF_PERIOD_CYC counter; tick is high during the last count.
module tick_prescaler #(
  parameter int HALF_PERIOD_CYC = 25000000,
  parameter int CNT_W           = 32
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF_PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] count_reg;

  assign tick = (count_reg == LAST_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + ONE_CNT;
    end
  end

endmodule

// File: rtl/tm1637_update_sched.sv
// Sequences full TM1637 refreshes (data cmd, address, four digits, control) over a
// byte driver, re-running whenever the blink tick fires or the displayed inputs change.
module tm1637_update_sched
  import tm1637_pkg::*;
#(
  parameter int HALF_PERIOD_CYC = 25000000,
  parameter int CNT_W           = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] digits,
  input  logic [2:0]  brightness,
  input  logic        disp_on,
  input  logic        colon_en,
  output logic [7:0]  tx_byte,
  output logic        tx_last,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        colon_phase
);

  logic         tick;
  logic         colon_phase_reg;
  logic         pending_reg, pending_next;
  logic [31:0]  digits_seen_reg;
  logic [2:0]   bright_seen_reg;
  logic         on_seen_reg;
  logic [31:0]  snap_digits_reg;
  logic [2:0]   snap_bright_reg;
  logic         snap_on_reg;
  logic         snap_colon_reg;
  sched_state_e state_reg, state_next;
  logic         start_reg, start_next;
  logic         take_snap;
  logic         change;
  logic         done_ok;
  logic [7:0]   ctrl_byte;
  logic [7:0]   dig_byte [4];

  tick_prescaler #(
    .HALF_PERIOD_CYC(HALF_PERIOD_CYC),
    .CNT_W          (CNT_W)
  ) u_prescaler (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign change = (digits != digits_seen_reg) || (brightness != bright_seen_reg) ||
                  (disp_on != on_seen_reg);
  // The driver may echo a stale done in the cycle we launch a byte; only later ones count.
  assign done_ok = tx_done & ~start_reg;
  assign ctrl_byte = CMD_CTRL_BASE | (8'(snap_on_reg) << CTRL_ON_BIT) | 8'(snap_bright_reg);

  for (genvar gi = 0; gi < 4; gi++) begin : g_dig
    if (gi == COLON_DIGIT) begin : g_colon
      assign dig_byte[gi] = snap_digits_reg[8*gi +: 8] | (8'(snap_colon_reg) << COLON_BIT);
    end else begin : g_plain
      assign dig_byte[gi] = snap_digits_reg[8*gi +: 8];
    end
  end

  // A new request arriving in the same cycle as a sequence launch must survive.
  assign pending_next = tick | change | (pending_reg & ~take_snap);

  always_comb begin
    state_next = state_reg;
    start_next = 1'b0;
    take_snap  = 1'b0;
    tx_byte    = 8'h00;
    tx_last    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          take_snap  = 1'b1;
          start_next = 1'b1;
          state_next = DCMD;
        end
      end
      DCMD: begin
        tx_byte = CMD_DATA_AUTO;
        tx_last = 1'b1;
        if (done_ok) begin
          state_next = ADDR;
          start_next = 1'b1;
        end
      end
      ADDR: begin
        tx_byte = CMD_ADDR0;
        if (done_ok) begin
          state_next = DIG0;
          start_next = 1'b1;
        end
      end
      DIG0, DIG1, DIG2: begin
        tx_byte = dig_byte[2'(state_reg - DIG0)];
        if (done_ok) begin
          state_next = sched_state_e'(state_reg + 3'd1);
          start_next = 1'b1;
        end
      end
      DIG3: begin
        tx_byte = dig_byte[3];
        tx_last = 1'b1;
        if (done_ok) begin
          state_next = CTRL;
          start_next = 1'b1;
        end
      end
      CTRL: begin
        tx_byte = ctrl_byte;
        tx_last = 1'b1;
        // Chain straight into the next refresh when one is already owed.
        if (done_ok) begin
          if (pending_reg) begin
            take_snap  = 1'b1;
            start_next = 1'b1;
            state_next = DCMD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      start_reg       <= 1'b0;
      pending_reg     <= 1'b1;
      colon_phase_reg <= 1'b1;
      digits_seen_reg <= '0;
      bright_seen_reg <= '0;
      on_seen_reg     <= 1'b0;
      snap_digits_reg <= '0;
      snap_bright_reg <= '0;
      snap_on_reg     <= 1'b0;
      snap_colon_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      start_reg       <= start_next;
      pending_reg     <= pending_next;
      colon_phase_reg <= colon_phase_reg ^ tick;
      digits_seen_reg <= digits;
      bright_seen_reg <= brightness;
      on_seen_reg     <= disp_on;
      if (take_snap) begin
        snap_digits_reg <= digits;
        snap_bright_reg <= brightness;
        snap_on_reg     <= disp_on;
        snap_colon_reg  <= colon_phase_reg & colon_en;
      end
    end
  end

  assign tx_start    = start_reg;
  assign busy        = (state_reg != IDLE);
  assign colon_phase = colon_phase_reg;

endmodule

// File: tb/tb_tm1637_update_sched.sv
// Directed bench for tm1637_update_sched with HALF_PERIOD_CYC=10 and a driver model that
// returns tx_done three cycles after each tx_start; byte order and timing are hand-derived.
module tb_tm1637_update_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] digits = 32'h3F06_5B4F;
  logic [2:0]  brightness = 3'd7;
  logic        disp_on = 1'b1;
  logic        colon_en = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_last;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic        colon_phase;

  logic        drv_done = 1'b0;
  logic        inj_done = 1'b0;
  assign tx_done = drv_done | inj_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int unstable    = 0;
  int drv_cnt     = 0;
  int drv_lat     = 3;
  int slow_byte   = -1;

  typedef struct {
    logic [7:0] b;
    logic       l;
    int         c;
  } rec_t;
  rec_t act_q[$];
  logic [7:0] cur_byte = 8'h00;
  logic       cur_last = 1'b0;

  tm1637_update_sched #(
    .HALF_PERIOD_CYC(10),
    .CNT_W          (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .digits     (digits),
    .brightness (brightness),
    .disp_on    (disp_on),
    .colon_en   (colon_en),
    .tx_byte    (tx_byte),
    .tx_last    (tx_last),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .busy       (busy),
    .colon_phase(colon_phase)
  );

  always #5 clock = ~clock;

  // Edge index since the last reset release: the first edge with reset low is 1.
  initial forever begin
    @(posedge clock);
    if (reset) cyc = 0;
    else cyc = cyc + 1;
  end

  // Byte monitor: log every launched byte and watch that it stays put until done.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (tx_start) begin
        act_q.push_back('{b: tx_byte, l: tx_last, c: cyc});
        cur_byte = tx_byte;
        cur_last = tx_last;
      end else if (busy && (tx_byte !== cur_byte || tx_last !== cur_last)) begin
        unstable++;
      end
    end
  end

  // Driver model; the first byte after reset can be made one cycle slower.
  initial forever begin
    @(negedge clock);
    drv_done = 1'b0;
    if (reset) begin
      drv_cnt = 0;
    end else if (tx_start) begin
      drv_lat = (drv_cnt == slow_byte) ? 4 : 3;
      drv_cnt++;
      for (int i = 0; i < drv_lat; i++) begin
        @(negedge clock);
        if (reset) break;
      end
      if (!reset) drv_done = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    int w;
    w = 0;
    while (cyc != k && w < 400) begin
      @(negedge clock);
      w++;
    end
    chk($sformatf("reach_cyc%0d", k), 32'(cyc), 32'(k));
  endtask

  // Expect n bytes of a refresh launched at edge s; dig1 already includes the colon bit.
  task automatic check_seq(input string tag, input int s, input logic [31:0] d,
                           input logic [7:0] dig1, input logic [7:0] ctrl,
                           input int n, input bit slow);
    logic [8:0] exp_b [7];
    rec_t r;
    int   w;
    int   ecyc;
    exp_b[0] = {1'b1, 8'h40};
    exp_b[1] = {1'b0, 8'hC0};
    exp_b[2] = {1'b0, d[7:0]};
    exp_b[3] = {1'b0, dig1};
    exp_b[4] = {1'b0, d[23:16]};
    exp_b[5] = {1'b1, d[31:24]};
    exp_b[6] = {1'b1, ctrl};
    w = 0;
    while (act_q.size() < n && w < 400) begin
      @(negedge clock);
      w++;
    end
    chk($sformatf("%s.count", tag), 32'(act_q.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (act_q.size() == 0) break;
      r = act_q.pop_front();
      ecyc = s + 4 * i + ((slow && i > 0) ? 1 : 0);
      chk($sformatf("%s.byte%0d", tag, i), 32'({r.l, r.b}), 32'(exp_b[i]));
      chk($sformatf("%s.cyc%0d", tag, i), 32'(r.c), 32'(ecyc));
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst.tx_start", 32'(tx_start), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.tx_byte", 32'(tx_byte), 32'h00);
    chk("rst.tx_last", 32'(tx_last), 32'd0);
    chk("rst.colon_phase", 32'(colon_phase), 32'd1);

    // Release with a stray done while idle; DCMD must launch right after the first edge.
    reset    = 1'b0;
    inj_done = 1'b1;
    @(negedge clock);
    inj_done = 1'b0;
    chk("first.tx_start", 32'(tx_start), 32'd1);
    chk("first.busy", 32'(busy), 32'd1);
    chk("first.tx_byte", 32'(tx_byte), 32'h40);
    chk("first.tx_last", 32'(tx_last), 32'd1);
    chk("first.colon_phase", 32'(colon_phase), 32'd1);
    colon_en = 1'b1;

    check_seq("seq1", 1, 32'h3F06_5B4F, 8'h5B, 8'h8F, 7, 1'b0);
    check_seq("seq2", 29, 32'h3F06_5B4F, 8'hDB, 8'h8F, 7, 1'b0);
    check_seq("seq3", 57, 32'h3F06_5B4F, 8'h5B, 8'h8F, 7, 1'b0);

    // Inputs change during DIG2 of seq4: seq4 keeps its snapshot, seq5 picks them up.
    wait_cyc(102);
    chk("mid.colon_phase", 32'(colon_phase), 32'd1);
    chk("mid.busy", 32'(busy), 32'd1);
    digits     = 32'h3F06_5B06;
    brightness = 3'd3;
    disp_on    = 1'b0;
    check_seq("seq4", 85, 32'h3F06_5B4F, 8'hDB, 8'h8F, 7, 1'b0);

    // Stray done in ADDR's launch cycle must not shorten that byte.
    wait_cyc(117);
    chk("inj.tx_start", 32'(tx_start), 32'd1);
    inj_done = 1'b1;
    @(negedge clock);
    inj_done = 1'b0;
    check_seq("seq5", 113, 32'h3F06_5B06, 8'h5B, 8'h83, 7, 1'b0);

    // Reset in the middle of DIG1's launch cycle of seq6.
    wait_cyc(153);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.tx_start", 32'(tx_start), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.tx_byte", 32'(tx_byte), 32'h00);
    chk("abort.tx_last", 32'(tx_last), 32'd0);
    chk("abort.colon_phase", 32'(colon_phase), 32'd1);
    check_seq("seq6", 141, 32'h3F06_5B06, 8'hDB, 8'h83, 4, 1'b0);
    chk("abort.leftover", 32'(act_q.size()), 32'd0);

    // Restart; a slow first byte makes CTRL's done land on the edge-30 tick.
    repeat (2) @(negedge clock);
    slow_byte = 0;
    reset     = 1'b0;
    check_seq("seqA", 1, 32'h3F06_5B06, 8'hDB, 8'h83, 7, 1'b1);
    check_seq("seqB", 30, 32'h3F06_5B06, 8'hDB, 8'h83, 7, 1'b0);
    check_seq("seqC", 58, 32'h3F06_5B06, 8'h5B, 8'h83, 7, 1'b0);

    chk("hold_stable", 32'(unstable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
